// File: rtl/timer_counter_if.sv
// Bus-side view of the timer: bridge-decoded word offset, write strobe, byte
// enables and write data in; combinational read data and the interrupt out.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  // Handshake: no valid/ready. A write is taken at the clock edge whenever
  // we=1, and rdata always reflects the register selected by addr.
  modport master (output addr, output we, output byteen, output wdata,
                  input rdata, input irq);
  modport slave  (input addr, input we, input byteen, input wdata,
                  output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with one-shot and auto-reload modes. Expiry sets
// an interrupt-pending flag that is gated by the CTRL.IM mask onto irq.
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  timer_counter_if.slave   bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q,  ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q,  count_d;
  logic        pend_q,   pend_d;

  logic        ctrl_en;
  logic        mode_reload;
  logic        wr_any;

  assign ctrl_en     = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_any      = bus.we && (bus.byteen != 4'b0000);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          pend_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_reload) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes are applied last so a CTRL write overrides the
    // hardware En clear from the INT state in the same cycle.
    if (wr_any) begin
      case (bus.addr)
        2'd0: begin
          if (bus.byteen[0]) ctrl_d = bus.wdata[3:0];
          pend_d = 1'b0;
        end
        2'd1:    preset_d = byte_merge(preset_q, bus.wdata, bus.byteen);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= PRESET_RST;
      count_q  <= 32'h0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'h0, ctrl_q};
      2'd1:    bus.rdata = preset_q;
      2'd2:    bus.rdata = count_q;
      default: bus.rdata = 32'h0;
    endcase
  end

  assign bus.irq   = pend_q & ctrl_q[3];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios with timeline expectations and a
// randomized run checked against a cycle-timeline reference model.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  timer_counter_if bus ();

  timer_counter #(.PRESET_RST(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_t is the number of edges since the enable was seen
  // (0 = idle, 1 = load, 2..p+2 = counting, p+3 = expiry).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_p;
  logic        m_pend;
  longint      m_t;

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic we, input logic [1:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count, n_p;
    logic        n_pend;
    longint      n_t, lp;
    if (rst) begin
      m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_p = 32'h0;
      m_pend = 1'b0; m_t = 0;
      return;
    end
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_p = m_p;
    n_pend = m_pend; n_t = m_t;
    lp = longint'(m_p);
    if (m_t == 0) begin
      if (m_ctrl[0]) n_t = 1;
    end else if (m_t == 1) begin
      n_count = m_preset; n_p = m_preset; n_t = 2;
    end else if (m_t <= lp + 2) begin
      if (!m_ctrl[0]) n_t = 0;
      else if (m_t < lp + 2) begin
        n_count = m_p - 32'(m_t - 1);
        n_t = m_t + 1;
      end else begin
        n_pend = 1'b1; n_t = lp + 3;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin
        n_pend = 1'b0; n_t = 1;
      end else begin
        n_ctrl[0] = 1'b0; n_t = 0;
      end
    end
    if (we && be != 4'b0000) begin
      if (a == 2'd0) begin
        if (be[0]) n_ctrl = wd[3:0];
        n_pend = 1'b0;
      end else if (a == 2'd1) begin
        for (int i = 0; i < 4; i++) if (be[i]) n_preset[8*i +: 8] = wd[8*i +: 8];
      end
    end
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_p = n_p;
    m_pend = n_pend; m_t = n_t;
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    reset = rst; bus.we = we; bus.addr = a; bus.byteen = be; bus.wdata = wd;
    @(posedge clk);
    model_step(rst, we, a, be, wd);
    @(negedge clk);
    reset = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.byteen = 4'h0; bus.wdata = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, a, 4'hF, wd);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL reset_rd%0d got %h want 00000000", a, d);
      end
    end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic exp;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      idle();
      exp = (k >= 8);
      n_cmp++;
      if (bus.irq !== exp) begin n_err++; $display("FAIL oneshot_irq k=%0d got %b want %b", k, bus.irq, exp); end
    end
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL oneshot_count got %h want 0", d); end
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl got %h want 8", d); end
    wr(2'd0, 32'h8);
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL oneshot_ack got %b want 0", bus.irq); end
  endtask

  task automatic test_periodic();
    logic exp;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      idle();
      exp = (k % 6 == 0);
      n_cmp++;
      if (bus.irq !== exp) begin n_err++; $display("FAIL periodic_irq k=%0d got %b want %b", k, bus.irq, exp); end
    end
    wr(2'd0, 32'h0);
    repeat (3) idle();
  endtask

  task automatic test_masked();
    logic [31:0] d;
    logic exp;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle();
      n_cmp++;
      if (bus.irq !== 1'b0) begin n_err++; $display("FAIL masked_irq k=%0d got %b want 0", k, bus.irq); end
      rd(2'd0, d);
      exp = (k <= 5);
      n_cmp++;
      if (d[0] !== exp) begin n_err++; $display("FAIL masked_en k=%0d got %b want %b", k, d[0], exp); end
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] d;
    wr(2'd1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 2'd1, 4'b0011, 32'hAAAA_5555);
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'hFFFF_5555) begin n_err++; $display("FAIL merge_preset got %h want ffff5555", d); end
    cycle(1'b0, 1'b1, 2'd1, 4'b0000, 32'h1234_5678);
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'hFFFF_5555) begin n_err++; $display("FAIL merge_be0 got %h want ffff5555", d); end
    wr(2'd2, $urandom | 32'h1);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL count_ro got %h want 0", d); end
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reserved_rd got %h want 0", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    repeat (11) idle();
    wr(2'd0, 32'h0);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd90) begin n_err++; $display("FAIL disable_count got %0d want 90", d); end
    repeat (3) idle();
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd90) begin n_err++; $display("FAIL disable_hold got %0d want 90", d); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL disable_irq got %b want 0", bus.irq); end
    wr(2'd0, 32'h1);
    idle();
    idle();
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd100) begin n_err++; $display("FAIL reenable_count got %0d want 100", d); end
    wr(2'd0, 32'h0);
    repeat (2) idle();
  endtask

  task automatic test_p0_and_mode_alias();
    logic [31:0] d;
    logic exp;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      exp = (k >= 3);
      n_cmp++;
      if (bus.irq !== exp) begin n_err++; $display("FAIL p0_irq k=%0d got %b want %b", k, bus.irq, exp); end
    end
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hD);
    for (int k = 1; k <= 7; k++) begin
      idle();
      exp = (k >= 4);
      n_cmp++;
      if (bus.irq !== exp) begin n_err++; $display("FAIL mode2_irq k=%0d got %b want %b", k, bus.irq, exp); end
    end
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'hC) begin n_err++; $display("FAIL mode2_ctrl got %h want c", d); end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    repeat (10) idle();
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_cmp++;
      if (d !== 32'h0) begin n_err++; $display("FAIL midreset_rd%0d got %h want 0", a, d); end
    end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_random();
    logic [31:0] d, wd;
    logic [1:0]  a;
    logic [3:0]  be;
    logic        rst;
    int          r;
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 99);
      rst = (r == 0);
      a   = 2'($urandom_range(0, 3));
      be  = 4'($urandom_range(0, 15));
      wd  = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      if (r < 60) cycle(rst, 1'b0, 2'd0, 4'h0, 32'h0);
      else cycle(rst, 1'b1, a, be, wd);
      n_cmp++;
      if (bus.irq !== (m_pend & m_ctrl[3])) begin
        n_err++; $display("FAIL rand_irq n=%0d got %b want %b", n, bus.irq, m_pend & m_ctrl[3]);
      end
      for (int k = 0; k < 4; k++) begin
        rd(2'(k), d);
        n_cmp++;
        if (d !== model_rd(2'(k))) begin
          n_err++; $display("FAIL rand_rd%0d n=%0d got %h want %h", k, n, d, model_rd(2'(k)));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.byteen = 4'h0; bus.wdata = 32'h0;
    model_step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_masked();
    test_byte_merge();
    test_disable();
    test_p0_and_mode_alias();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
